// File: rtl/seq_detect_1011.sv
// Overlapping "1011" serial sequence detector: Moore FSM with a registered
// match flag, a saturating match counter and a debug view of the state.
module seq_detect_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en,
  input  logic             d,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             match_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cnt_inc_s;

  // Next-state decode; any encoding outside S0..S4 recovers to S0 even when en is low.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S0: begin
        if (en) state_nxt_s = d ? S1 : S0;
        else    state_nxt_s = state_r;
      end
      S1: begin
        if (en) state_nxt_s = d ? S1 : S2;
        else    state_nxt_s = state_r;
      end
      S2: begin
        if (en) state_nxt_s = d ? S3 : S0;
        else    state_nxt_s = state_r;
      end
      S3: begin
        if (en) state_nxt_s = d ? S4 : S2;
        else    state_nxt_s = state_r;
      end
      S4: begin
        if (en) state_nxt_s = d ? S1 : S2;
        else    state_nxt_s = state_r;
      end
      default: state_nxt_s = S0;
    endcase
  end

  // Counter update: clear beats increment, increment sticks at all-ones.
  always_comb begin
    cnt_inc_s = 1'b0;
    cnt_nxt_s = cnt_r;
    if (en && (state_r <= S4) && (state_nxt_s == S4)) begin
      cnt_inc_s = 1'b1;
    end else begin
      cnt_inc_s = 1'b0;
    end
    if (cnt_clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, match flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r <= S0;
      match_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      match_r <= (state_nxt_s == S4);
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign match     = match_r;
  assign match_cnt = cnt_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Scoreboard bench for seq_detect_1011: a default-width and a 2-bit-counter
// instance share stimulus; a reference model predicts every edge.
module tb_seq_detect_1011;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       en = 1'b0;
  logic       d = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       match8, match2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [2:0] st8, st2;

  typedef struct {
    logic [2:0] st;
    logic       m;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  logic [2:0] m_st;
  logic       m_m;
  logic [7:0] m_c8;
  logic [1:0] m_c2;
  bit         saw_match;

  always #5 clk = ~clk;

  seq_detect_1011 #(.CNT_W(8)) dut8 (
    .clk(clk), .areset(areset), .en(en), .d(d), .cnt_clr(cnt_clr),
    .match(match8), .match_cnt(cnt8), .state_o(st8)
  );

  seq_detect_1011 #(.CNT_W(2)) dut2 (
    .clk(clk), .areset(areset), .en(en), .d(d), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .state_o(st2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    ref_next = b ? 3'd1 : 3'd0;
      3'd1:    ref_next = b ? 3'd1 : 3'd2;
      3'd2:    ref_next = b ? 3'd3 : 3'd0;
      3'd3:    ref_next = b ? 3'd4 : 3'd2;
      3'd4:    ref_next = b ? 3'd1 : 3'd2;
      default: ref_next = 3'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic dd, input logic c);
    exp_t x;
    logic [2:0] ns;
    logic inc;
    @(negedge clk);
    areset = r; en = e; d = dd; cnt_clr = c;
    if (r) begin
      m_st = 3'd0; m_m = 1'b0; m_c8 = 8'd0; m_c2 = 2'd0;
    end else begin
      ns  = (m_st > 3'd4) ? 3'd0 : (e ? ref_next(m_st, dd) : m_st);
      inc = e && (m_st <= 3'd4) && (ns == 3'd4);
      m_st = ns;
      m_m  = (ns == 3'd4);
      if (c) begin
        m_c8 = 8'd0; m_c2 = 2'd0;
      end else if (inc) begin
        if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
        if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
      end
    end
    x.st = m_st; x.m = m_m; x.c8 = m_c8; x.c2 = m_c2;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check_eq("sb_state8", {29'd0, st8}, {29'd0, x.st});
      check_eq("sb_match8", {31'd0, match8}, {31'd0, x.m});
      check_eq("sb_cnt8", {24'd0, cnt8}, {24'd0, x.c8});
      check_eq("sb_state2", {29'd0, st2}, {29'd0, x.st});
      check_eq("sb_match2", {31'd0, match2}, {31'd0, x.m});
      check_eq("sb_cnt2", {30'd0, cnt2}, {30'd0, x.c2});
    end
    if (match8 === 1'b1) saw_match = 1'b1;
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], 1'b0);
  endtask

  initial begin
    // basic detection after a two-cycle reset
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("rst_state", {29'd0, st8}, 32'd0);
    check_eq("rst_match", {31'd0, match8}, 32'd0);
    check_eq("rst_cnt", {24'd0, cnt8}, 32'd0);
    bits(16'b1011, 4);
    check_eq("basic_match", {31'd0, match8}, 32'd1);
    check_eq("basic_state", {29'd0, st8}, 32'd4);
    check_eq("basic_cnt", {24'd0, cnt8}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("basic_drop", {31'd0, match8}, 32'd0);
    check_eq("basic_s2", {29'd0, st8}, 32'd2);

    // overlapping matches
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b1011011, 7);
    check_eq("ovl_match", {31'd0, match8}, 32'd1);
    check_eq("ovl_cnt", {24'd0, cnt8}, 32'd2);

    // enable gating holds state at S2
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b10, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, (i % 2) == 0, 1'b0);
      check_eq("gate_hold", {29'd0, st8}, 32'd2);
    end
    bits(16'b11, 2);
    check_eq("gate_match", {31'd0, match8}, 32'd1);
    check_eq("gate_cnt", {24'd0, cnt8}, 32'd1);

    // reset mid-sequence discards partial match and clears the count
    bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("mid_state", {29'd0, st8}, 32'd0);
    check_eq("mid_match", {31'd0, match8}, 32'd0);
    check_eq("mid_cnt", {24'd0, cnt8}, 32'd0);
    bits(16'b1011, 4);
    check_eq("mid_after", {24'd0, cnt8}, 32'd1);

    // saturation of the 2-bit counter, then clear against a 4th-bit edge
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b1011011011, 10);
    check_eq("sat_3rd", {30'd0, cnt2}, 32'd3);
    bits(16'b011011, 6);
    check_eq("sat_hold", {30'd0, cnt2}, 32'd3);
    check_eq("sat_wide", {24'd0, cnt8}, 32'd5);
    bits(16'b01, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("clr_match", {31'd0, match2}, 32'd1);
    check_eq("clr_cnt2", {30'd0, cnt2}, 32'd0);
    check_eq("clr_cnt8", {24'd0, cnt8}, 32'd0);

    // cnt_clr while disabled clears the count but keeps state
    bits(16'b011, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_dis_cnt", {24'd0, cnt8}, 32'd0);
    check_eq("clr_dis_state", {29'd0, st8}, 32'd4);
    check_eq("clr_dis_match", {31'd0, match8}, 32'd1);

    // negative pattern never matches
    step(1'b1, 1'b0, 1'b0, 1'b0);
    saw_match = 1'b0;
    bits(16'b1110010, 7);
    check_eq("neg_nomatch", {31'd0, saw_match}, 32'd0);
    check_eq("neg_cnt", {24'd0, cnt8}, 32'd0);
    check_eq("neg_state", {29'd0, st8}, 32'd2);

    // random mix of enable, data, clear and occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
